// File: rtl/mem_channel_responder.sv
// Multi-channel memory responder: each channel waits a fixed latency, then channels
// share one single-port word array through a round-robin arbiter; a load port preempts all.
module mem_channel_responder #(
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 16,
   parameter int NUM_CHANNELS = 4,
   parameter int LATENCY      = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
   input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
   output logic [NUM_CHANNELS-1:0]           mem_read_ready,
   output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
   input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
   input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
   output logic [NUM_CHANNELS-1:0]           mem_write_ready,
   input  logic                              load_valid,
   input  logic [ADDR_BITS-1:0]              load_address,
   input  logic [DATA_BITS-1:0]              load_data
);

   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic [2:0] {IDLE, WAIT, ARB, RESP, DROP} state_t;

   state_t                 state   [NUM_CHANNELS];
   logic [3:0]             count   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] op_write;
   logic [ADDR_BITS-1:0]   addr_q  [NUM_CHANNELS];
   logic [DATA_BITS-1:0]   wdata_q [NUM_CHANNELS];
   logic [DATA_BITS-1:0]   rdata_q [NUM_CHANNELS];

   logic [ADDR_BITS-1:0]   rd_addr [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]   wr_addr [NUM_CHANNELS];
   logic [DATA_BITS-1:0]   wr_data [NUM_CHANNELS];

   logic [DATA_BITS-1:0]   mem [DEPTH];

   logic [NUM_CHANNELS-1:0] arb_req;
   logic [NUM_CHANNELS-1:0] grant;
   logic                    grant_any;
   logic [CH_W-1:0]         grant_idx;
   logic [CH_W-1:0]         ptr;

   logic [ADDR_BITS-1:0]   acc_addr;
   logic [DATA_BITS-1:0]   acc_wdata;
   logic [DATA_BITS-1:0]   acc_rdata;
   logic                   acc_write;

   function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_CHANNELS) s -= NUM_CHANNELS;
      return CH_W'(s);
   endfunction

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      assign rd_addr[g] = mem_read_address[g*ADDR_BITS +: ADDR_BITS];
      assign wr_addr[g] = mem_write_address[g*ADDR_BITS +: ADDR_BITS];
      assign wr_data[g] = mem_write_data[g*DATA_BITS +: DATA_BITS];
      assign mem_read_data[g*DATA_BITS +: DATA_BITS] = rdata_q[g];
      assign arb_req[g] = (state[g] == ARB);
   end

   // Round-robin search starting at ptr; the load port and reset block every grant.
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      if (!load_valid && !reset) begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (!grant_any && arb_req[wrap_add(ptr, k)]) begin
               grant_any = 1'b1;
               grant_idx = wrap_add(ptr, k);
            end
         end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
   end

   assign acc_addr  = addr_q[grant_idx];
   assign acc_wdata = wdata_q[grant_idx];
   assign acc_write = op_write[grant_idx];
   assign acc_rdata = mem[acc_addr];

   // Array contents survive reset; only one port access happens per cycle.
   always_ff @(posedge clk) begin
      if (load_valid) begin
         mem[load_address] <= load_data;
      end else if (grant_any && acc_write) begin
         mem[acc_addr] <= acc_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr             <= '0;
         mem_read_ready  <= '0;
         mem_write_ready <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            state[i]   <= IDLE;
            rdata_q[i] <= '0;
         end
      end else begin
         mem_read_ready  <= '0;
         mem_write_ready <= '0;
         if (grant_any) ptr <= wrap_add(grant_idx, 1);
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            case (state[i])
               IDLE: begin
                  if (mem_read_valid[i] || mem_write_valid[i]) begin
                     op_write[i] <= !mem_read_valid[i];
                     addr_q[i]   <= mem_read_valid[i] ? rd_addr[i] : wr_addr[i];
                     wdata_q[i]  <= wr_data[i];
                     count[i]    <= 4'(LATENCY);
                     state[i]    <= (LATENCY == 0) ? ARB : WAIT;
                  end
               end
               WAIT: begin
                  if (count[i] == 4'd1) state[i] <= ARB;
                  else                  count[i] <= count[i] - 4'd1;
               end
               ARB: begin
                  if (grant[i]) begin
                     if (op_write[i]) begin
                        mem_write_ready[i] <= 1'b1;
                     end else begin
                        mem_read_ready[i] <= 1'b1;
                        rdata_q[i]        <= acc_rdata;
                     end
                     state[i] <= RESP;
                  end
               end
               RESP: state[i] <= DROP;
               // Wait for the initiator to retire the completed request before re-arming.
               DROP: begin
                  if (op_write[i] ? !mem_write_valid[i] : !mem_read_valid[i]) state[i] <= IDLE;
               end
               default: state[i] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_channel_responder.sv
// Bench for mem_channel_responder: directed scenarios plus randomized traffic, scored
// against a transaction-level model of latency, round-robin arbitration and array contents.
module tb_mem_channel_responder;

   localparam int AB  = 8;
   localparam int DB  = 16;
   localparam int NCH = 4;
   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NCH-1:0]    rv = '0, wv = '0, rr, wr;
   logic [NCH*AB-1:0] ra = '0, wa = '0;
   logic [NCH*DB-1:0] rd, wd = '0;
   logic              load_valid = 1'b0;
   logic [AB-1:0]     load_address = '0;
   logic [DB-1:0]     load_data = '0;

   mem_channel_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NCH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr), .mem_read_data(rd),
      .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr),
      .load_valid(load_valid), .load_address(load_address), .load_data(load_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   bit mon_en = 0;

   // Reference model: each request becomes eligible LAT+1 edges after acceptance,
   // one eligible request is served per edge in round-robin order, loads preempt.
   typedef enum int {M_IDLE, M_PEND, M_RET} mph_t;
   typedef struct {int ch; bit wr; logic [DB-1:0] data; int ed;} exp_t;

   logic [DB-1:0] mem_m   [256];
   mph_t          ph      [NCH];
   bit            m_wr    [NCH];
   logic [AB-1:0] m_addr  [NCH];
   logic [DB-1:0] m_data  [NCH];
   int            elig    [NCH];
   int            ret_from[NCH];
   logic [DB-1:0] rd_hold [NCH];
   int            ptr_m = 0;
   exp_t          sb[$];

   always @(posedge clk) begin
      int c, g;
      exp_t me;
      edge_n++;
      if (load_valid) mem_m[load_address] = load_data;
      if (reset) begin
         ptr_m = 0;
         for (int ch = 0; ch < NCH; ch++) begin
            ph[ch] = M_IDLE;
            rd_hold[ch] = '0;
         end
      end else begin
         g = -1;
         if (!load_valid) begin
            for (int k = 0; k < NCH; k++) begin
               c = (ptr_m + k) % NCH;
               if (g < 0 && ph[c] == M_PEND && elig[c] <= edge_n) g = c;
            end
         end
         if (g >= 0) begin
            me.ch = g; me.wr = m_wr[g]; me.ed = edge_n;
            if (m_wr[g]) begin
               mem_m[m_addr[g]] = m_data[g];
               me.data = m_data[g];
            end else begin
               me.data = mem_m[m_addr[g]];
               rd_hold[g] = me.data;
            end
            sb.push_back(me);
            ph[g] = M_RET;
            ret_from[g] = edge_n + 2;
            ptr_m = (g + 1) % NCH;
         end
         for (int ch = 0; ch < NCH; ch++) begin
            if (ph[ch] == M_IDLE && (rv[ch] || wv[ch])) begin
               m_wr[ch]   = !rv[ch];
               m_addr[ch] = rv[ch] ? ra[ch*AB +: AB] : wa[ch*AB +: AB];
               m_data[ch] = wd[ch*DB +: DB];
               elig[ch]   = edge_n + LAT + 1;
               ph[ch]     = M_PEND;
            end else if (ph[ch] == M_RET && edge_n >= ret_from[ch] &&
                         !(m_wr[ch] ? wv[ch] : rv[ch])) begin
               ph[ch] = M_IDLE;
            end
         end
      end
   end

   // Monitor: every ready pulse must match the head of the scoreboard at the right edge.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         for (int ch = 0; ch < NCH; ch++) begin
            checks++;
            if (rd[ch*DB +: DB] !== rd_hold[ch]) begin
               errors++;
               $display("FAIL rdata_hold ch%0d edge %0d: got 0x%0h, expected 0x%0h",
                        ch, edge_n, rd[ch*DB +: DB], rd_hold[ch]);
            end
            if (rr[ch] || wr[ch]) begin
               checks++;
               if (sb.size() == 0 || sb[0].ch != ch || sb[0].ed != edge_n) begin
                  errors++;
                  $display("FAIL unexpected_ready ch%0d edge %0d: got rd_rdy=%0b wr_rdy=%0b, expected no completion",
                           ch, edge_n, rr[ch], wr[ch]);
               end else begin
                  e = sb.pop_front();
                  if ((e.wr && !(wr[ch] && !rr[ch])) ||
                      (!e.wr && !(rr[ch] && !wr[ch] && rd[ch*DB +: DB] === e.data))) begin
                     errors++;
                     $display("FAIL response ch%0d edge %0d: got rd_rdy=%0b wr_rdy=%0b data=0x%0h, expected write=%0b data=0x%0h",
                              ch, edge_n, rr[ch], wr[ch], rd[ch*DB +: DB], e.wr, e.data);
                  end
               end
            end
         end
         while (sb.size() > 0 && sb[0].ed <= edge_n) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_ready ch%0d: got no completion at edge %0d, expected write=%0b data=0x%0h",
                     e.ch, e.ed, e.wr, e.data);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_ch(input int ch, input bit r, input bit w, input logic [AB-1:0] a, input logic [DB-1:0] d);
      rv[ch] = r;
      wv[ch] = w;
      ra[ch*AB +: AB] = a;
      wa[ch*AB +: AB] = a;
      wd[ch*DB +: DB] = d;
   endtask

   task automatic req(input int ch, input bit w, input logic [AB-1:0] a, input logic [DB-1:0] d,
                      input int hold, output int lat, output logic [DB-1:0] q);
      int e0;
      bit got;
      @(negedge clk);
      set_ch(ch, !w, w, a, d);
      e0 = edge_n + 1;
      got = 0; lat = -1; q = '0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         if (w ? wr[ch] : rr[ch]) begin
            got = 1;
            lat = edge_n - e0;
            q = rd[ch*DB +: DB];
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL req_timeout ch%0d: got no ready within 100 cycles, expected one", ch);
      end
      repeat (hold) @(negedge clk);
      rv[ch] = 1'b0;
      wv[ch] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic burst(input int tag);
      int e0;
      int redge[NCH];
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) begin
         set_ch(ch, 1'b1, 1'b0, 8'(8'h40 + ch), '0);
         redge[ch] = -1;
      end
      e0 = edge_n + 1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         for (int ch = 0; ch < NCH; ch++) begin
            if (redge[ch] < 0 && rr[ch]) begin
               redge[ch] = edge_n - e0;
               rv[ch] = 1'b0;
            end
         end
      end
      for (int ch = 0; ch < NCH; ch++) check($sformatf("burst%0d_ch%0d_latency", tag, ch), redge[ch], 3 + ch);
   endtask

   task automatic random_phase(input int ncyc);
      bit act[NCH], waiting[NCH];
      int gap[NCH], hold[NCH], age[NCH];
      int kind;
      for (int ch = 0; ch < NCH; ch++) begin
         act[ch] = 0; waiting[ch] = 0; gap[ch] = $urandom_range(0, 3); hold[ch] = 0; age[ch] = 0;
      end
      for (int t = 0; t < ncyc + 400; t++) begin
         @(negedge clk);
         load_valid   = (t < ncyc) && ($urandom_range(0, 7) == 0);
         load_address = 8'($urandom_range(0, 15));
         load_data    = 16'($urandom);
         for (int ch = 0; ch < NCH; ch++) begin
            if (!act[ch]) begin
               if (gap[ch] > 0) gap[ch]--;
               else if (t < ncyc) begin
                  kind = $urandom_range(0, 4);
                  set_ch(ch, kind <= 1 || kind == 4, kind >= 2, 8'($urandom_range(0, 15)), 16'($urandom));
                  act[ch] = 1; waiting[ch] = 1; age[ch] = 0;
               end
            end else if (waiting[ch]) begin
               age[ch]++;
               if (rr[ch] || wr[ch]) begin
                  waiting[ch] = 0;
                  hold[ch] = $urandom_range(0, 2);
               end else if (age[ch] > 200) begin
                  checks++; errors++;
                  $display("FAIL random_timeout ch%0d: got no ready within 200 cycles, expected one", ch);
                  waiting[ch] = 0;
                  hold[ch] = 0;
               end else if ($urandom_range(0, 15) == 0) begin
                  rv[ch] = 1'b0;
                  wv[ch] = 1'b0;
               end
            end
            if (act[ch] && !waiting[ch]) begin
               if (hold[ch] > 0) hold[ch]--;
               else begin
                  rv[ch] = 1'b0; wv[ch] = 1'b0;
                  act[ch] = 0;
                  gap[ch] = 1 + $urandom_range(0, 3);
               end
            end
         end
      end
      load_valid = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, got;
      logic [DB-1:0] q;

      repeat (3) @(negedge clk);
      mon_en = 1;
      for (int ch = 0; ch < NCH; ch++) begin
         check($sformatf("reset_rd_ready%0d", ch), rr[ch], 0);
         check($sformatf("reset_wr_ready%0d", ch), wr[ch], 0);
         check($sformatf("reset_rdata%0d", ch), rd[ch*DB +: DB], 0);
      end
      reset = 1'b0;

      for (int a = 0; a < 256; a++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_address = 8'(a);
         load_data = (a == 8'h20) ? 16'h0000 : 16'($urandom);
      end
      @(negedge clk);
      load_valid = 1'b1; load_address = 8'h05; load_data = 16'h1234;
      @(negedge clk);
      load_valid = 1'b0;

      req(0, 1'b0, 8'h05, '0, 0, lat, q);
      check("read_latency", lat, 3);
      check("read_loaded", q, 16'h1234);

      req(1, 1'b1, 8'h10, 16'hBEEF, 0, lat, q);
      check("write_latency", lat, 3);
      req(1, 1'b0, 8'h10, '0, 0, lat, q);
      check("read_after_write", q, 16'hBEEF);

      req(3, 1'b0, 8'h05, '0, 0, lat, q);
      burst(1);
      burst(2);

      @(negedge clk);
      set_ch(2, 1'b1, 1'b0, 8'h30, '0);
      lat = edge_n + 1;
      got = -1;
      for (int n = 1; n <= 40 && got < 0; n++) begin
         @(negedge clk);
         if (rr[2]) begin
            got = edge_n - lat;
            q = rd[2*DB +: DB];
         end
         load_valid = (n >= 3 && n <= 5);
         load_address = 8'h30;
         load_data = 16'h5A5A;
      end
      load_valid = 1'b0;
      rv[2] = 1'b0;
      check("load_stall_latency", got, 6);
      check("load_stall_data", q, 16'h5A5A);
      repeat (2) @(negedge clk);

      req(0, 1'b0, 8'h05, '0, 2, lat, q);
      check("hold_read_data", q, 16'h1234);
      req(0, 1'b0, 8'h10, '0, 0, lat, q);
      check("after_hold_latency", lat, 3);
      check("after_hold_data", q, 16'hBEEF);

      @(negedge clk);
      set_ch(0, 1'b0, 1'b1, 8'h20, 16'hAAAA);
      @(negedge clk);
      reset = 1'b1;
      rv = '0; wv = '0;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_ready", {rr, wr}, 0);
      check("midreset_rdata", rd, 0);
      repeat (8) @(negedge clk);
      req(0, 1'b0, 8'h20, '0, 0, lat, q);
      check("dropped_write", q, 16'h0000);
      req(1, 1'b0, 8'h05, '0, 0, lat, q);
      check("loaded_intact", q, 16'h1234);

      random_phase(3000);

      repeat (10) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
